// File: rtl/rtc_bus_writer.sv
// Write-only driver for the RTC's multiplexed Intel-style bus: one accepted
// request becomes an address phase then a data phase, followed by a fin pulse.
module rtc_bus_writer #(
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 1,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escribe,
    input  logic [7:0] dir_out,
    input  logic [7:0] dato_out,
    output logic       fin,
    output logic       busy,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad_n,
    output logic [7:0] ad_bus,
    output logic       ad_oe
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_A_SETUP = 4'd1;
    localparam logic [3:0] S_A_PULSE = 4'd2;
    localparam logic [3:0] S_A_HOLD  = 4'd3;
    localparam logic [3:0] S_D_SETUP = 4'd4;
    localparam logic [3:0] S_D_PULSE = 4'd5;
    localparam logic [3:0] S_D_HOLD  = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_RELEASE = 4'd8;

    localparam logic [CW-1:0] LAST_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LAST_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LAST_HOLD  = CW'(T_HOLD - 1);

    logic [3:0]    state_reg, state_next;
    logic [CW-1:0] counter_reg, counter_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    data_reg, data_next;

    logic          timed;
    logic [CW-1:0] limit;
    logic [3:0]    follow;

    logic       fin_next, busy_next, cs_n_next, wr_n_next, ad_n_next, ad_oe_next;
    logic [7:0] ad_bus_next;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        timed        = 1'b0;
        limit        = '0;
        follow       = S_IDLE;

        case (state_reg)
            S_IDLE: begin
                counter_next = '0;
                if (escribe) begin
                    addr_next  = dir_out;
                    data_next  = dato_out;
                    state_next = S_A_SETUP;
                end
            end
            S_A_SETUP: begin timed = 1'b1; limit = LAST_SETUP; follow = S_A_PULSE; end
            S_A_PULSE: begin timed = 1'b1; limit = LAST_PULSE; follow = S_A_HOLD;  end
            S_A_HOLD:  begin timed = 1'b1; limit = LAST_HOLD;  follow = S_D_SETUP; end
            S_D_SETUP: begin timed = 1'b1; limit = LAST_SETUP; follow = S_D_PULSE; end
            S_D_PULSE: begin timed = 1'b1; limit = LAST_PULSE; follow = S_D_HOLD;  end
            S_D_HOLD:  begin timed = 1'b1; limit = LAST_HOLD;  follow = S_DONE;    end
            S_DONE:    state_next = S_RELEASE;
            // Requester may still hold escribe after fin; wait for it to drop.
            S_RELEASE: if (!escribe) state_next = S_IDLE;
            default: begin
                state_next   = S_IDLE;
                counter_next = '0;
            end
        endcase

        if (timed) begin
            if (counter_reg == limit) begin
                state_next   = follow;
                counter_next = '0;
            end else begin
                counter_next = counter_reg + CW'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        fin_next    = 1'b0;
        busy_next   = (state_next != S_IDLE);
        cs_n_next   = 1'b1;
        wr_n_next   = 1'b1;
        ad_n_next   = 1'b1;
        ad_oe_next  = 1'b0;
        ad_bus_next = 8'h00;
        case (state_next)
            S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
                cs_n_next   = 1'b0;
                ad_n_next   = 1'b0;
                ad_oe_next  = 1'b1;
                ad_bus_next = addr_next;
                wr_n_next   = (state_next != S_A_PULSE);
            end
            S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
                cs_n_next   = 1'b0;
                ad_oe_next  = 1'b1;
                ad_bus_next = data_next;
                wr_n_next   = (state_next != S_D_PULSE);
            end
            S_DONE: fin_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            addr_reg    <= 8'h00;
            data_reg    <= 8'h00;
            fin         <= 1'b0;
            busy        <= 1'b0;
            cs_n        <= 1'b1;
            wr_n        <= 1'b1;
            rd_n        <= 1'b1;
            ad_n        <= 1'b1;
            ad_bus      <= 8'h00;
            ad_oe       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            fin         <= fin_next;
            busy        <= busy_next;
            cs_n        <= cs_n_next;
            wr_n        <= wr_n_next;
            rd_n        <= 1'b1;
            ad_n        <= ad_n_next;
            ad_bus      <= ad_bus_next;
            ad_oe       <= ad_oe_next;
        end
    end

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Directed bench for rtc_bus_writer: default timing instance plus a
// timing-override instance sharing the same request inputs.
module tb_rtc_bus_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       escribe;
    logic [7:0] dir_out;
    logic [7:0] dato_out;
    logic       sel;

    logic       fin0, busy0, cs_n0, wr_n0, rd_n0, ad_n0, ad_oe0;
    logic [7:0] ad_bus0;
    logic       fin1, busy1, cs_n1, wr_n1, rd_n1, ad_n1, ad_oe1;
    logic [7:0] ad_bus1;

    logic       m_fin, m_busy, m_cs_n, m_wr_n, m_rd_n, m_ad_n, m_ad_oe;
    logic [7:0] m_ad_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_bus_writer dut (
        .clk(clk), .reset(reset), .escribe(escribe), .dir_out(dir_out), .dato_out(dato_out),
        .fin(fin0), .busy(busy0), .cs_n(cs_n0), .wr_n(wr_n0), .rd_n(rd_n0),
        .ad_n(ad_n0), .ad_bus(ad_bus0), .ad_oe(ad_oe0)
    );

    rtc_bus_writer #(.T_SETUP(2), .T_PULSE(1), .T_HOLD(3), .CW(4)) dut_ovr (
        .clk(clk), .reset(reset), .escribe(escribe), .dir_out(dir_out), .dato_out(dato_out),
        .fin(fin1), .busy(busy1), .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1),
        .ad_n(ad_n1), .ad_bus(ad_bus1), .ad_oe(ad_oe1)
    );

    assign m_fin    = sel ? fin1    : fin0;
    assign m_busy   = sel ? busy1   : busy0;
    assign m_cs_n   = sel ? cs_n1   : cs_n0;
    assign m_wr_n   = sel ? wr_n1   : wr_n0;
    assign m_rd_n   = sel ? rd_n1   : rd_n0;
    assign m_ad_n   = sel ? ad_n1   : ad_n0;
    assign m_ad_oe  = sel ? ad_oe1  : ad_oe0;
    assign m_ad_bus = sel ? ad_bus1 : ad_bus0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request: returns fin latency (edges after accept), wr_n-low counts
    // and captured bus values per phase; holds escribe `hold` cycles after fin.
    task automatic run_write(input logic [7:0] a, input logic [7:0] d, input int hold,
                             input bit change_inputs, output int lat,
                             output int wl_a, output int wl_d,
                             output logic [7:0] cap_a, output logic [7:0] cap_d);
        bit cs_ok = 1'b1;
        bit rd_ok = 1'b1;
        lat = -1; wl_a = 0; wl_d = 0; cap_a = 8'hxx; cap_d = 8'hxx;
        @(negedge clk);
        dir_out = a; dato_out = d; escribe = 1'b1;
        @(posedge clk); #1;
        check("busy_at_accept", 32'(m_busy), 32'd1);
        if (m_cs_n) cs_ok = 1'b0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (change_inputs && c == 2) begin
                dir_out = 8'h41; dato_out = 8'h08;
            end
            if (!m_rd_n) rd_ok = 1'b0;
            if (m_fin) begin
                lat = c;
                check("done_bus_idle", {23'd0, m_cs_n, m_ad_oe, m_ad_bus}, {23'd0, 1'b1, 1'b0, 8'h00});
            end else begin
                if (m_cs_n) cs_ok = 1'b0;
                if (!m_wr_n) begin
                    if (!m_ad_n) begin wl_a++; cap_a = m_ad_bus; end
                    else begin wl_d++; cap_d = m_ad_bus; end
                end
            end
        end
        check("cs_low_whole_cycle", 32'(cs_ok), 32'd1);
        check("rd_n_high", 32'(rd_ok), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("held_no_restart", {29'd0, m_cs_n, m_busy, m_fin}, {29'd0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        escribe = 1'b0;
        @(posedge clk); #1;
        check("busy_drop_after_release", 32'(m_busy), 32'd0);
        $display("write sel=%0d addr=%02h data=%02h lat=%0d wl_a=%0d wl_d=%0d bus_a=%02h bus_d=%02h",
                 sel, a, d, lat, wl_a, wl_d, cap_a, cap_d);
    endtask

    int lat, wl_a, wl_d;
    logic [7:0] cap_a, cap_d;
    logic [7:0] seq_addr [9];
    bit found, fin_seen, cs_act;

    initial begin
        seq_addr = '{8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'h41, 8'h42, 8'h43};
        reset = 1'b1; escribe = 1'b0; dir_out = 8'h00; dato_out = 8'h00; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {17'd0, m_cs_n, m_wr_n, m_rd_n, m_ad_n, m_ad_bus, m_ad_oe, m_fin, m_busy},
              {17'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {30'd0, m_cs_n, m_busy}, {30'd0, 1'b1, 1'b0});

        // Single write with request held 5 cycles past fin
        run_write(8'h21, 8'h45, 5, 1'b0, lat, wl_a, wl_d, cap_a, cap_d);
        check("single_latency", 32'(lat), 32'd12);
        check("single_wr_low_addr", 32'(wl_a), 32'd4);
        check("single_wr_low_data", 32'(wl_d), 32'd4);
        check("single_bus_addr", 32'(cap_a), 32'h21);
        check("single_bus_data", 32'(cap_d), 32'h45);

        // Fresh request with inputs changed after accept
        run_write(8'h21, 8'h45, 1, 1'b1, lat, wl_a, wl_d, cap_a, cap_d);
        check("chg_latency", 32'(lat), 32'd12);
        check("chg_bus_addr", 32'(cap_a), 32'h21);
        check("chg_bus_data", 32'(cap_d), 32'h45);

        // Reset during the data strobe
        @(negedge clk);
        dir_out = 8'h21; dato_out = 8'h45; escribe = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (!m_wr_n && m_ad_n) found = 1'b1;
        end
        check("reach_d_pulse", 32'(found), 32'd1);
        @(negedge clk); reset = 1'b1; escribe = 1'b0;
        @(posedge clk); #1;
        check("abort_outputs", {27'd0, m_cs_n, m_wr_n, m_ad_oe, m_fin, m_busy},
              {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk); reset = 1'b0;
        fin_seen = 1'b0; cs_act = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (m_fin) fin_seen = 1'b1;
            if (!m_cs_n) cs_act = 1'b1;
        end
        check("abort_no_fin", 32'(fin_seen), 32'd0);
        check("abort_no_bus", 32'(cs_act), 32'd0);
        $display("abort write during data strobe, fin_seen=%0d", fin_seen);

        // Nine user registers back to back
        for (int i = 0; i < 9; i++) begin
            run_write(seq_addr[i], seq_addr[i] ^ 8'hA5, 1, 1'b0, lat, wl_a, wl_d, cap_a, cap_d);
            check("seq_latency", 32'(lat), 32'd12);
            check("seq_bus_addr", 32'(cap_a), 32'(seq_addr[i]));
            check("seq_bus_data", 32'(cap_d), 32'(seq_addr[i] ^ 8'hA5));
        end

        // Timing override instance
        sel = 1'b1;
        run_write(8'h37, 8'h5C, 2, 1'b0, lat, wl_a, wl_d, cap_a, cap_d);
        check("ovr_latency", 32'(lat), 32'd12);
        check("ovr_wr_low_addr", 32'(wl_a), 32'd1);
        check("ovr_wr_low_data", 32'(wl_d), 32'd1);
        check("ovr_bus_addr", 32'(cap_a), 32'h37);
        check("ovr_bus_data", 32'(cap_d), 32'h5C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
